cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, is the program counter value loaded on reset.
REQ-002 The port `clock` SHALL be an input, 1 bit wide, and the sole clock; all state updates on its rising edge.
REQ-003 The port `clear` SHALL be an input, 1 bit wide, and the reset, which is synchronous and active-high.
REQ-004 The port `clock_enable` SHALL be an input, 1 bit wide; when low, all registers hold.
REQ-005 The port `mem_data` SHALL be an input, 8 bits wide, carrying the byte at `pc` from combinational program memory, valid in the same cycle.
REQ-006 The ports `alu_zero` and `alu_carry` SHALL be inputs, 1 bit each, carrying the combinational ALU result flags.
REQ-007 The port `pc` SHALL be an output, 8 bits wide, driving the program memory address.
REQ-008 The ports `ir` and `operand` SHALL be outputs, 8 bits each, carrying the latched opcode byte and operand byte.
REQ-009 The ports `fetch`, `decode` and `execute` SHALL be outputs, 1 bit each, as one-hot phase indicators.
REQ-010 The port `alu_op` SHALL be an output, 2 bits wide, encoded 00 add, 01 sub, 10 and.
REQ-011 The port `acc_sel` SHALL be an output, 2 bits wide, encoded 00 operand, 01 ALU, 10 input port.
REQ-012 The ports `acc_we` and `out_we` SHALL be outputs, 1 bit each, as single-cycle write strobes.
REQ-013 The ports `flag_z`, `flag_c` and `halted` SHALL be outputs, 1 bit each, carrying the registered flags and the halt status.

Function
REQ-014 Opcode is ir[7:4], decoded as follows:
- 0000 LOAD#
- 0100 ADD#
- 0001 SUB#
- 0110 AND#
- 1000 JUMP
- 1001 JCOND
- 0101 INPUT
- 0111 OUTPUT
- 1111 HALT
- all others NOP.

REQ-015 Two-byte instructions are LOAD, ADD, SUB, AND, JUMP and JCOND; all other instructions are one byte.
REQ-016 States are FETCH, DECODE, OPERAND, EXECUTE and HALT.
REQ-017 FETCH: ir <= mem_data, pc <= pc+1, next state DECODE.
REQ-018 DECODE: next state OPERAND for a two-byte instruction; next state HALT for opcode 1111; otherwise next state EXECUTE.
REQ-019 OPERAND: operand <= mem_data, pc <= pc+1, next state EXECUTE.
REQ-020 EXECUTE: assert that instruction's strobes for exactly 1 cycle, then next state FETCH.
REQ-021 Latency SHALL be 3 cycles for a one-byte instruction and 4 cycles for a two-byte instruction, measured FETCH to FETCH.
REQ-022 Phase indicators:
- `fetch` = FETCH
- `decode` = DECODE or OPERAND
- `execute` = EXECUTE
- all three low in HALT.

REQ-023 LOAD: acc_we=1, acc_sel=00.
REQ-024 ADD, SUB and AND: acc_we=1, acc_sel=01, alu_op per REQ-010, and flag_z <= alu_zero, flag_c <= alu_carry, all in EXECUTE.
REQ-025 INPUT: acc_we=1, acc_sel=10.
REQ-026 OUTPUT: out_we=1.
REQ-027 NOP: no strobes.
REQ-028 JUMP: pc <= operand.
REQ-029 JCOND:
- cond = ir[2] ? flag_c : flag_z
- taken when cond XOR ir[3]
- if taken, pc <= operand; otherwise pc is unchanged (already past the operand).

REQ-030 JCOND SHALL use the flags registered before its EXECUTE, never the live ALU inputs.
REQ-031 Only ADD, SUB and AND SHALL modify the flags.
REQ-032 Outside EXECUTE, acc_we=0, out_we=0, alu_op=00 and acc_sel=00.
REQ-033 pc SHALL wrap 8'hFF -> 8'h00 on increment, including during an operand fetch.
REQ-034 HALT SHALL be sticky, with halted=1, pc frozen and no strobes, and SHALL be left only by clear.
REQ-035 With clock_enable low, state, pc, ir, operand and flags SHALL hold; strobes stay asserted if held in EXECUTE, but the external datapath must also gate on clock_enable.

Reset
REQ-036 On clear=1 at a rising edge, regardless of clock_enable: state=FETCH, pc=RESET_PC, ir=8'h00, operand=8'h00, flag_z=0, flag_c=0, halted=0.
REQ-037 clear asserted in any state, including mid-instruction or HALT, SHALL abort the instruction with no strobe issued after that edge.
REQ-038 clear has priority over clock_enable and over every state transition.

Configuration
REQ-039 Macro SEQ_SINGLE_STEP_EN:
- When defined, it adds input `step` (1 bit) and state PAUSE.
- EXECUTE goes to PAUSE, not FETCH.
- PAUSE goes to FETCH in the cycle after step=1 is sampled.
- All phase indicators are low in PAUSE.
- clear exits PAUSE to FETCH.

REQ-040 When SEQ_SINGLE_STEP_EN is undefined, there SHALL be no `step` port and no PAUSE state, and EXECUTE goes directly to FETCH.

Verification
REQ-041 Memory 00:00 01:2A, clear released -> fetch@c0, decode@c1-c2, acc_we=1 with acc_sel=00 and operand=8'h2A @c3, fetch@c4 with pc=8'h02.
REQ-042 ADD# 0x05 with alu_zero=1, alu_carry=1 in EXECUTE, then 9C 10 (JNC) -> not taken, pc=8'h04; replaced by 94 10 (JC) -> pc=8'h10.
REQ-043 RESET_PC=8'hFF, memory FF:80, 00:33 -> operand fetched from 8'h00 after wrap, then pc=8'h33.
REQ-044 HALT at 8'h05 -> halted=1, pc=8'h06 constant for 20 cycles; clear -> pc=RESET_PC, halted=0.
REQ-045 clock_enable low for 5 cycles during OPERAND of SUB -> all outputs constant; on resume, alu_op=01 and acc_we=1 exactly once.
REQ-046 clear during the EXECUTE of JUMP 8'h40 -> pc=RESET_PC, not 8'h40; with SEQ_SINGLE_STEP_EN, the next FETCH occurs only after the step pulse.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/OPERAND/EXECUTE sequencer for an
// 8-bit accumulator CPU with combinational program memory and external ALU.
// Optional build macro SEQ_SINGLE_STEP_EN adds a `step` input and a PAUSE
// state entered after every EXECUTE; left undefined, EXECUTE returns to FETCH.
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       clock_enable,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] mem_data,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       fetch,
  output logic       decode,
  output logic       execute,
  output logic [1:0] alu_op,
  output logic [1:0] acc_sel,
  output logic       acc_we,
  output logic       out_we,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXECUTE,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  typedef enum logic [3:0] {
    OP_LOAD   = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_ADD    = 4'b0100,
    OP_INPUT  = 4'b0101,
    OP_AND    = 4'b0110,
    OP_OUTPUT = 4'b0111,
    OP_JUMP   = 4'b1000,
    OP_JCOND  = 4'b1001,
    OP_HALT   = 4'b1111
  } opcode_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_operand;
  logic       r_fz;
  logic       r_fc;

  opcode_t    w_opc;
  logic       w_two_byte;
  logic       w_is_alu;
  logic       w_cond;
  logic       w_taken;

  assign w_opc      = opcode_t'(r_ir[7:4]);
  assign w_two_byte = (w_opc == OP_LOAD) || (w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                      (w_opc == OP_AND)  || (w_opc == OP_JUMP) || (w_opc == OP_JCOND);
  assign w_is_alu   = (w_opc == OP_ADD) || (w_opc == OP_SUB) || (w_opc == OP_AND);
  // Conditional jumps test the registered flags, never the live ALU flags.
  assign w_cond     = r_ir[2] ? r_fc : r_fz;
  assign w_taken    = w_cond ^ r_ir[3];

  assign pc      = r_pc;
  assign ir      = r_ir;
  assign operand = r_operand;
  assign flag_z  = r_fz;
  assign flag_c  = r_fc;

  // State register: clear wins over clock_enable and every transition.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_FETCH;
    end else if (clock_enable) begin
      r_state <= w_next;
    end
  end

  // Program counter, instruction/operand latches and flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_operand <= '0;
      r_fz      <= 1'b0;
      r_fc      <= 1'b0;
    end else if (clock_enable) begin
      case (r_state)
        S_FETCH: begin
          r_ir <= mem_data;
          r_pc <= r_pc + 8'd1;
        end
        S_OPERAND: begin
          r_operand <= mem_data;
          r_pc      <= r_pc + 8'd1;
        end
        S_EXECUTE: begin
          if (w_is_alu) begin
            r_fz <= alu_zero;
            r_fc <= alu_carry;
          end
          if ((w_opc == OP_JUMP) || ((w_opc == OP_JCOND) && w_taken)) begin
            r_pc <= r_operand;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        if (w_two_byte)             w_next = S_OPERAND;
        else if (w_opc == OP_HALT)  w_next = S_HALT;
        else                        w_next = S_EXECUTE;
      end
      S_OPERAND: w_next = S_EXECUTE;
`ifdef SEQ_SINGLE_STEP_EN
      S_EXECUTE: w_next = S_PAUSE;
      S_PAUSE:   if (step) w_next = S_FETCH;
`else
      S_EXECUTE: w_next = S_FETCH;
`endif
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  // Phase indicators and EXECUTE-only datapath strobes.
  always_comb begin
    fetch   = (r_state == S_FETCH);
    decode  = (r_state == S_DECODE) || (r_state == S_OPERAND);
    execute = (r_state == S_EXECUTE);
    halted  = (r_state == S_HALT);
    alu_op  = 2'b00;
    acc_sel = 2'b00;
    acc_we  = 1'b0;
    out_we  = 1'b0;
    if (r_state == S_EXECUTE) begin
      case (w_opc)
        OP_LOAD:   acc_we = 1'b1;
        OP_ADD:    begin acc_we = 1'b1; acc_sel = 2'b01; alu_op = 2'b00; end
        OP_SUB:    begin acc_we = 1'b1; acc_sel = 2'b01; alu_op = 2'b01; end
        OP_AND:    begin acc_we = 1'b1; acc_sel = 2'b01; alu_op = 2'b10; end
        OP_INPUT:  begin acc_we = 1'b1; acc_sel = 2'b10; end
        OP_OUTPUT: out_we = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes expected observations,
// a negedge monitor pops and compares on DUT events (fetch / write strobes)
// or on explicit per-cycle snapshot requests.
`timescale 1ns/1ps
module tb_cpu_sequencer;

  localparam int X = -1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       clear, clear2, clock_enable;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step;
`endif
  logic [7:0] mem [256];

  logic [7:0] md1, pc1, ir1, opd1;
  logic       az1, ac1, f1, d1, e1, awe1, owe1, fz1, fc1, h1;
  logic [1:0] aop1, asel1;
  logic [7:0] md2, pc2, ir2, opd2;
  logic       az2, ac2, f2, d2, e2, awe2, owe2, fz2, fc2, h2;
  logic [1:0] aop2, asel2;

  // Program memory and ALU flag model: add -> z1 c1, sub -> z0 c1, and -> z0 c0
  assign md1 = mem[pc1];
  assign md2 = mem[pc2];
  assign az1 = (aop1 == 2'b00);
  assign ac1 = (aop1 != 2'b10);
  assign az2 = (aop2 == 2'b00);
  assign ac2 = (aop2 != 2'b10);

  cpu_sequencer u_dut (
    .clock(clock), .clear(clear), .clock_enable(clock_enable),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_data(md1), .alu_zero(az1), .alu_carry(ac1),
    .pc(pc1), .ir(ir1), .operand(opd1),
    .fetch(f1), .decode(d1), .execute(e1),
    .alu_op(aop1), .acc_sel(asel1), .acc_we(awe1), .out_we(owe1),
    .flag_z(fz1), .flag_c(fc1), .halted(h1)
  );

  cpu_sequencer #(.RESET_PC(8'hFF)) u_dut_ff (
    .clock(clock), .clear(clear2), .clock_enable(clock_enable),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_data(md2), .alu_zero(az2), .alu_carry(ac2),
    .pc(pc2), .ir(ir2), .operand(opd2),
    .fetch(f2), .decode(d2), .execute(e2),
    .alu_op(aop2), .acc_sel(asel2), .acc_we(awe2), .out_we(owe2),
    .flag_z(fz2), .flag_c(fc2), .halted(h2)
  );

  logic [35:0] o1, o2;
  assign o1 = {pc1, opd1, ir1, f1, d1, e1, aop1, asel1, awe1, owe1, fz1, fc1, h1};
  assign o2 = {pc2, opd2, ir2, f2, d2, e2, aop2, asel2, awe2, owe2, fz2, fc2, h2};

  typedef struct {
    string       name;
    bit          on2;
    logic [35:0] exp;
    logic [35:0] msk;
  } chk_t;

  chk_t evq[$];
  chk_t nowq[$];
  int   n_run  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   done   = 1'b0;
  int   cyc    = 0;
  int   stall  = 0;
  bit   popped;
  chk_t mc;

  // Field order: pc, operand, ir, {fetch,decode,execute}, alu_op, acc_sel,
  // acc_we, out_we, flag_z, flag_c, halted. Negative value = don't care.
  function automatic chk_t mk(string n, int p, int opd, int irv, int ph, int aop,
                              int asel, int awe, int owe, int fz, int fc, int hlt);
    chk_t c;
    int   v[11];
    int   w[11];
    int   pos;
    v = '{p, opd, irv, ph, aop, asel, awe, owe, fz, fc, hlt};
    w = '{8, 8, 8, 3, 2, 2, 1, 1, 1, 1, 1};
    c.name = n; c.on2 = 1'b0; c.exp = '0; c.msk = '0; pos = 36;
    for (int f = 0; f < 11; f++) begin
      pos -= w[f];
      if (v[f] >= 0) begin
        for (int b = 0; b < w[f]; b++) begin
          c.exp[pos+b] = v[f][b];
          c.msk[pos+b] = 1'b1;
        end
      end
    end
    return c;
  endfunction

  function automatic chk_t F(string n, int p, int fz, int fc);
    return mk(n, p, X, X, 4, 0, 0, 0, 0, fz, fc, 0);
  endfunction

  function automatic chk_t S(string n, int irv, int opd, int aop, int asel, int awe, int owe);
    return mk(n, X, opd, irv, 1, aop, asel, awe, owe, X, X, 0);
  endfunction

  task automatic check(input chk_t c, input logic [35:0] a);
    n_run++;
    if ((a & c.msk) !== (c.exp & c.msk)) begin
      n_fail++;
      $display("FAIL %s: actual=%09h required=%09h care=%09h", c.name, a, c.exp, c.msk);
    end
  endtask

  // Monitor: snapshot requests first, otherwise any fetch/strobe event pops one entry.
  always @(negedge clock) begin
    cyc++;
    popped = 1'b0;
    if (nowq.size() > 0) begin
      mc = nowq.pop_front();
      check(mc, mc.on2 ? o2 : o1);
    end else if (mon_en && (f1 || awe1 || owe1)) begin
      if (evq.size() > 0) begin
        mc = evq.pop_front();
        check(mc, o1);
        popped = 1'b1;
      end else begin
        n_run++; n_fail++;
        $display("FAIL unexpected_event: actual=%09h required=no event", o1);
      end
    end
    if (evq.size() > 0 && !popped) stall++;
    else stall = 0;
    if (stall > 80) begin
      n_run++; n_fail++;
      $display("FAIL event_timeout: actual=no event required=%s", evq[0].name);
      evq.delete();
      stall = 0;
    end
    if (done || cyc > 3000) begin
      if (cyc > 3000) begin
        n_run++; n_fail++;
        $display("FAIL global_timeout: actual=%0d cycles required=<=3000", cyc);
      end
      if (evq.size() > 0) begin
        n_run++; n_fail++;
        $display("FAIL leftover_events: actual=%0d pending required=0", evq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (evq.size() == 0) break;
      @(negedge clock);
    end
  endtask

  initial begin
    clear = 1'b1; clear2 = 1'b1; clock_enable = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    foreach (mem[i]) mem[i] = 8'h20;
    mem[8'h00] = 8'h00; mem[8'h01] = 8'h2A;   // LOAD #2A
    mem[8'h02] = 8'h40; mem[8'h03] = 8'h05;   // ADD #05
    mem[8'h04] = 8'h9C; mem[8'h05] = 8'h10;   // JNC 10
    mem[8'h06] = 8'h94; mem[8'h07] = 8'h10;   // JC 10
    mem[8'h10] = 8'h60; mem[8'h11] = 8'h03;   // AND #03
    mem[8'h12] = 8'h98; mem[8'h13] = 8'h20;   // JNZ 20
    mem[8'h20] = 8'h50;                       // INPUT
    mem[8'h21] = 8'h70;                       // OUTPUT
    mem[8'h22] = 8'h20;                       // NOP
    mem[8'h23] = 8'h80; mem[8'h24] = 8'h30;   // JUMP 30
    mem[8'h30] = 8'h14; mem[8'h31] = 8'h07;   // SUB #07
    mem[8'h32] = 8'h91; mem[8'h33] = 8'h40;   // JZ 40
    mem[8'h34] = 8'hF0;                       // HALT

    tick(); tick();
    clear = 1'b0;
    nowq.push_back(mk("reset_state", 8'h00, 8'h00, 8'h00, 4, 0, 0, 0, 0, 0, 0, 0));
    mon_en = 1'b1;
    evq.push_back(S("load",         8'h00, 8'h2A, 0, 0, 1, 0));
    evq.push_back(F("fetch_02",     8'h02, 0, 0));
    evq.push_back(S("add",          8'h40, 8'h05, 0, 1, 1, 0));
    evq.push_back(F("fetch_04",     8'h04, 1, 1));
    evq.push_back(F("jnc_not_taken",8'h06, 1, 1));
    evq.push_back(F("jc_taken",     8'h10, 1, 1));
    evq.push_back(S("and",          8'h60, 8'h03, 2, 1, 1, 0));
    evq.push_back(F("fetch_12",     8'h12, 0, 0));
    evq.push_back(F("jnz_taken",    8'h20, 0, 0));
    evq.push_back(S("input",        8'h50, 8'h20, 0, 2, 1, 0));
    evq.push_back(F("fetch_21",     8'h21, 0, 0));
    evq.push_back(S("output",       8'h70, 8'h20, 0, 0, 0, 1));
    evq.push_back(F("fetch_22",     8'h22, 0, 0));
    evq.push_back(F("fetch_23",     8'h23, 0, 0));
    evq.push_back(F("jump",         8'h30, 0, 0));
    evq.push_back(S("sub_resume",   8'h14, 8'h07, 1, 1, 1, 0));
    evq.push_back(F("fetch_32",     8'h32, 0, 1));
    evq.push_back(F("jz_not_taken", 8'h34, 0, 1));

    // Stall the SUB in OPERAND for five enable-low edges.
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (f1 && pc1 == 8'h30) break;
    end
    tick(); tick();
    clock_enable = 1'b0;
    nowq.push_back(mk("hold_operand", 8'h31, 8'h30, 8'h14, 2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tick();
      nowq.push_back(mk("hold_operand", 8'h31, 8'h30, 8'h14, 2, 0, 0, 0, 0, 0, 0, 0));
    end
    clock_enable = 1'b1;

    drain();
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      nowq.push_back(mk("halt_sticky", 8'h35, X, 8'hF0, 0, 0, 0, 0, 0, 0, 1, 1));
      tick();
    end

    mem[8'h00] = 8'h80; mem[8'h01] = 8'h40;   // JUMP 40
    mem[8'h40] = 8'hF0;                       // HALT
    clear = 1'b1;
    tick();
    clear = 1'b0;
    nowq.push_back(mk("clear_from_halt", 8'h00, 8'h00, 8'h00, 4, 0, 0, 0, 0, 0, 0, 0));
    tick(); tick(); tick();
    nowq.push_back(mk("jump_execute", 8'h02, 8'h40, 8'h80, 1, 0, 0, 0, 0, 0, 0, 0));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    nowq.push_back(mk("clear_in_execute", 8'h00, 8'h00, 8'h00, 4, 0, 0, 0, 0, 0, 0, 0));
    evq.push_back(F("refetch_after_abort", 8'h40, 0, 0));
    drain();
    tick(); tick();

    // RESET_PC = FF instance: operand byte comes from address 00 after wrap.
    mem[8'hFF] = 8'h80; mem[8'h00] = 8'h33;
    clear2 = 1'b0;
    mc = mk("ff_reset",   8'hFF, 8'h00, 8'h00, 4, 0, 0, 0, 0, 0, 0, 0); mc.on2 = 1'b1; nowq.push_back(mc);
    tick();
    mc = mk("ff_wrap_pc", 8'h00, X,     8'h80, 2, 0, 0, 0, 0, 0, 0, 0); mc.on2 = 1'b1; nowq.push_back(mc);
    tick();
    mc = mk("ff_operand", 8'h00, X,     8'h80, 2, 0, 0, 0, 0, 0, 0, 0); mc.on2 = 1'b1; nowq.push_back(mc);
    tick();
    mc = mk("ff_execute", 8'h01, 8'h33, 8'h80, 1, 0, 0, 0, 0, 0, 0, 0); mc.on2 = 1'b1; nowq.push_back(mc);
    tick();
    mc = mk("ff_jump",    8'h33, 8'h33, X,     4, 0, 0, 0, 0, 0, 0, 0); mc.on2 = 1'b1; nowq.push_back(mc);
    tick();
    done = 1'b1;
  end

endmodule
